sram_bank_arbiter: RTL and testbench



---
 rtl/sram_bank_arbiter.sv | 85 ++++++++
 tb/tb_sram_bank_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: single-port SRAM arbiter for engine, loader and debug with debug anti-starvation
module sram_bank_arbiter #(
    parameter int pADDR_WIDTH   = 10,
    parameter int pDATA_WIDTH   = 64,
    parameter int pSTARVE_LIMIT = 15
) (
    input  logic                   axi_clk,
    input  logic                   axi_reset_n,
    input  logic                   eng_lock,
    input  logic                   eng_req,
    input  logic                   eng_we,
    input  logic [pADDR_WIDTH-1:0] eng_adr,
    input  logic [pDATA_WIDTH-1:0] eng_d,
    output logic                   eng_gnt,
    output logic                   eng_qvld,
    input  logic                   ld_req,
    input  logic                   ld_we,
    input  logic [pADDR_WIDTH-1:0] ld_adr,
    input  logic [pDATA_WIDTH-1:0] ld_d,
    output logic                   ld_gnt,
    output logic                   ld_qvld,
    input  logic                   dbg_req,
    input  logic [pADDR_WIDTH-1:0] dbg_adr,
    output logic                   dbg_gnt,
    output logic                   dbg_qvld,
    output logic [pDATA_WIDTH-1:0] rd_q,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [pADDR_WIDTH-1:0] ram_adr,
    output logic [pDATA_WIDTH-1:0] ram_d,
    input  logic [pDATA_WIDTH-1:0] ram_q,
    output logic [7:0]             starve_cnt
);
    localparam int CW = $clog2(pSTARVE_LIMIT + 2);

    logic [CW-1:0] wait_q, wait_d;
    logic [7:0]    starve_q, starve_d;
    logic          eng_rd_q, ld_rd_q, dbg_rd_q;
    logic          force_dbg;

    // grant selection: forced debug beats everything except the lock, else engine > loader > debug
    always_comb begin
        force_dbg = axi_reset_n & ~eng_lock & dbg_req & (wait_q == CW'(pSTARVE_LIMIT));
        eng_gnt   = axi_reset_n & eng_req & ~force_dbg;
        ld_gnt    = axi_reset_n & ~eng_lock & ld_req & ~eng_req & ~force_dbg;
        dbg_gnt   = force_dbg | (axi_reset_n & ~eng_lock & dbg_req & ~eng_req & ~ld_req);
    end

    // SRAM port driven by the granted requester, debug always reads, idle drives zeros
    always_comb begin
        ram_en  = eng_gnt | ld_gnt | dbg_gnt;
        ram_we  = (eng_gnt & eng_we) | (ld_gnt & ld_we);
        ram_adr = eng_gnt ? eng_adr : ld_gnt ? ld_adr : dbg_gnt ? dbg_adr : '0;
        ram_d   = eng_gnt ? eng_d : ld_gnt ? ld_d : '0;
    end

    // starvation tracking frozen while the engine holds the lock
    always_comb begin
        wait_d   = eng_lock ? wait_q : (dbg_req & ~dbg_gnt) ? wait_q + 1'b1 : '0;
        starve_d = (force_dbg && starve_q != 8'hFF) ? starve_q + 8'd1 : starve_q;
    end

    // state registers and one-stage read-return tags
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wait_q   <= '0;
            starve_q <= '0;
            eng_rd_q <= 1'b0;
            ld_rd_q  <= 1'b0;
            dbg_rd_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_d;
            eng_rd_q <= eng_gnt & ~eng_we;
            ld_rd_q  <= ld_gnt & ~ld_we;
            dbg_rd_q <= dbg_gnt;
        end
    end

    assign eng_qvld   = eng_rd_q;
    assign ld_qvld    = ld_rd_q;
    assign dbg_qvld   = dbg_rd_q;
    assign rd_q       = ram_q;
    assign starve_cnt = starve_q;
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter: randomized bench with a behavioural arbiter/memory model and directed scenarios
module tb_sram_bank_arbiter;
    localparam int AW = 10;
    localparam int DW = 64;
    localparam int LIM = 15;
    localparam int NONE = 0, ENG = 1, LD = 2, DBG = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          eng_lock = 0, eng_req = 0, eng_we = 0;
    logic [AW-1:0] eng_adr = '0;
    logic [DW-1:0] eng_d = '0;
    logic          ld_req = 0, ld_we = 0;
    logic [AW-1:0] ld_adr = '0;
    logic [DW-1:0] ld_d = '0;
    logic          dbg_req = 0;
    logic [AW-1:0] dbg_adr = '0;
    logic [DW-1:0] ram_q = '0;
    logic          eng_gnt, eng_qvld, ld_gnt, ld_qvld, dbg_gnt, dbg_qvld, ram_en, ram_we;
    logic [DW-1:0] rd_q, ram_d;
    logic [AW-1:0] ram_adr;
    logic [7:0]    starve_cnt;

    sram_bank_arbiter #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pSTARVE_LIMIT(LIM)) dut (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .eng_lock(eng_lock), .eng_req(eng_req), .eng_we(eng_we), .eng_adr(eng_adr), .eng_d(eng_d),
        .eng_gnt(eng_gnt), .eng_qvld(eng_qvld),
        .ld_req(ld_req), .ld_we(ld_we), .ld_adr(ld_adr), .ld_d(ld_d), .ld_gnt(ld_gnt), .ld_qvld(ld_qvld),
        .dbg_req(dbg_req), .dbg_adr(dbg_adr), .dbg_gnt(dbg_gnt), .dbg_qvld(dbg_qvld),
        .rd_q(rd_q), .ram_en(ram_en), .ram_we(ram_we), .ram_adr(ram_adr), .ram_d(ram_d),
        .ram_q(ram_q), .starve_cnt(starve_cnt)
    );

    logic [DW-1:0] sram    [1<<AW];
    logic [DW-1:0] ref_mem [1<<AW];

    // SRAM behaviour driven by the DUT's port
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) sram[ram_adr] <= ram_d;
            else ram_q <= sram[ram_adr];
        end
    end

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int m_wait = 0, m_starve = 0, m_pend = NONE, m_lastg = NONE;
    logic [DW-1:0] m_pdata = '0;

    function automatic int exp_g();
        if (!rst_n) return NONE;
        if (!eng_lock && dbg_req && m_wait == LIM) return DBG;
        if (eng_req) return ENG;
        if (eng_lock) return NONE;
        if (ld_req) return LD;
        if (dbg_req) return DBG;
        return NONE;
    endfunction

    // reference model advances once per clock
    always @(posedge clk) begin : model
        int g;
        bit forced, we;
        logic [AW-1:0] a;
        if (!rst_n) begin
            m_wait = 0; m_starve = 0; m_pend = NONE; m_lastg = NONE;
        end else begin
            g = exp_g();
            forced = !eng_lock && dbg_req && m_wait == LIM;
            we = (g == ENG && eng_we) || (g == LD && ld_we);
            a = g == ENG ? eng_adr : g == LD ? ld_adr : dbg_adr;
            m_pdata = ref_mem[a];
            if (g != NONE && we) ref_mem[a] = g == ENG ? eng_d : ld_d;
            m_pend = (g != NONE && !we) ? g : NONE;
            if (!eng_lock) m_wait = (dbg_req && g != DBG) ? m_wait + 1 : 0;
            if (forced && m_starve < 255) m_starve++;
            m_lastg = g;
        end
    end

    // compare every output against the model on each falling edge
    always @(negedge clk) begin : compare
        int g, p;
        bit we;
        if (chk_en) begin
            g = exp_g();
            p = rst_n ? m_pend : NONE;
            we = (g == ENG && eng_we) || (g == LD && ld_we);
            check("eng_gnt", eng_gnt, g == ENG);
            check("ld_gnt", ld_gnt, g == LD);
            check("dbg_gnt", dbg_gnt, g == DBG);
            check("ram_en", ram_en, g != NONE);
            check("ram_we", ram_we, we);
            check("ram_adr", ram_adr, g == ENG ? eng_adr : g == LD ? ld_adr : g == DBG ? dbg_adr : '0);
            check("ram_d", ram_d, g == ENG ? eng_d : g == LD ? ld_d : '0);
            check("eng_qvld", eng_qvld, p == ENG);
            check("ld_qvld", ld_qvld, p == LD);
            check("dbg_qvld", dbg_qvld, p == DBG);
            if (p != NONE) check("rd_q", rd_q, m_pdata);
            check("starve_cnt", starve_cnt, rst_n ? m_starve : 0);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        eng_req = 0; ld_req = 0; dbg_req = 0; eng_lock = 0;
    endtask

    initial begin
        bit ok;
        int eng_pct;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = {32'(i) * 32'h9E3779B9, 32'(i)};
            ref_mem[i] = sram[i];
        end
        sram[5] = 64'hA5A5;
        ref_mem[5] = 64'hA5A5;
        #1 rst_n = 0;
        #1 chk_en = 1;
        eng_req = 1; ld_req = 1;
        @(negedge clk);
        check("reset_gnt", {eng_gnt, ld_gnt, dbg_gnt, ram_en}, 4'b0000);
        check("reset_starve", starve_cnt, 8'd0);
        idle();
        nxt(); nxt();
        rst_n = 1;
        nxt();
        eng_req = 1; eng_we = 0; eng_adr = 10'h005;
        @(negedge clk);
        check("eng_rd_gnt", {eng_gnt, ram_en, ram_we}, 3'b110);
        nxt(); idle();
        @(negedge clk);
        check("eng_rd_qvld", eng_qvld, 1'b1);
        check("eng_rd_data", rd_q, 64'hA5A5);
        nxt();
        eng_req = 1; eng_adr = 10'h001; ld_req = 1; ld_we = 0; ld_adr = 10'h002; dbg_req = 1; dbg_adr = 10'h003;
        @(negedge clk);
        check("prio_all", {eng_gnt, ld_gnt, dbg_gnt}, 3'b100);
        nxt(); eng_req = 0;
        @(negedge clk);
        check("prio_ld", {eng_gnt, ld_gnt, dbg_gnt}, 3'b010);
        nxt(); ld_req = 0;
        nxt(); idle();
        nxt();
        eng_lock = 1; eng_req = 1; eng_we = 1; eng_adr = 10'h007; eng_d = 64'h77; dbg_req = 1; dbg_adr = 10'h009;
        ok = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dbg_gnt) ok = 0;
            nxt();
        end
        check("lock_no_dbg", ok, 1'b1);
        check("lock_starve", starve_cnt, 8'd0);
        idle();
        nxt();
        eng_req = 1; eng_we = 1; eng_adr = 10'h008; eng_d = 64'h88; dbg_req = 1; dbg_adr = 10'h009;
        ok = 1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c < 16 && (dbg_gnt || !eng_gnt)) ok = 0;
            if (c == 16) check("starve_force", {eng_gnt, dbg_gnt}, 2'b01);
            nxt();
        end
        check("starve_wait", ok, 1'b1);
        @(negedge clk);
        check("starve_cnt1", starve_cnt, 8'd1);
        check("eng_regain", {eng_gnt, dbg_gnt, dbg_qvld}, 3'b101);
        nxt(); idle();
        nxt();
        ld_req = 1; ld_we = 1; ld_adr = 10'h3FF; ld_d = 64'h1234;
        @(negedge clk);
        check("ld_wr_gnt", {ld_gnt, ram_we}, 2'b11);
        nxt(); ld_req = 0; dbg_req = 1; dbg_adr = 10'h3FF;
        @(negedge clk);
        check("dbg_rd_gnt", dbg_gnt, 1'b1);
        nxt(); idle();
        @(negedge clk);
        check("dbg_qvld", dbg_qvld, 1'b1);
        check("dbg_rd_data", rd_q, 64'h1234);
        nxt();
        eng_req = 1; eng_we = 0; eng_adr = 10'h005;
        @(negedge clk);
        check("pre_rst_gnt", eng_gnt, 1'b1);
        nxt(); idle(); rst_n = 0;
        @(negedge clk);
        check("rst_qvld", {eng_qvld, ld_qvld, dbg_qvld}, 3'b000);
        nxt(); nxt();
        rst_n = 1;
        @(negedge clk);
        check("post_rst_qvld", {eng_qvld, ld_qvld, dbg_qvld}, 3'b000);
        check("post_rst_starve", starve_cnt, 8'd0);
        nxt();
        eng_pct = 90;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) eng_pct = (eng_pct == 90) ? 35 : 90;
            if ($urandom_range(0, 24) == 0) eng_lock = ~eng_lock;
            if (!(eng_req && m_lastg != ENG)) begin
                eng_req = $urandom_range(0, 99) < eng_pct;
                eng_we = 1'($urandom_range(0, 1));
                eng_adr = AW'($urandom_range(0, 15));
                eng_d = {$urandom(), $urandom()};
            end
            if (!(ld_req && m_lastg != LD)) begin
                ld_req = $urandom_range(0, 99) < 50;
                ld_we = 1'($urandom_range(0, 1));
                ld_adr = AW'($urandom_range(0, 15));
                ld_d = {$urandom(), $urandom()};
            end
            if (!(dbg_req && m_lastg != DBG)) begin
                dbg_req = $urandom_range(0, 99) < 60;
                dbg_adr = AW'($urandom_range(0, 15));
            end
            nxt();
        end
        idle();
        nxt();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
